// File: rtl/cmp_issuer.sv
// -----------------------------------------------------------------------------
// cmp_issuer
//
// Initiator that sits between the ALU control path and CMP_UNIT. It takes one
// compare request at a time on a valid/ready port, presents the operands and
// function code to CMP_UNIT with a single-cycle cmp_en strobe, waits for
// cmp_flag, and returns the captured cmp_out on a valid/ready response port
// that tolerates arbitrary backpressure.
//
// Optional feature macro: CMP_ISSUER_TIMEOUT_EN
//   When defined, a watchdog bounds the time spent waiting for cmp_flag and
//   turns an expired wait into an error response. When undefined, the issuer
//   waits for cmp_flag indefinitely.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   req_valid  : request present
//   req_ready  : request accepted when req_valid & req_ready
//   req_a      : operand A
//   req_b      : operand B
//   req_fun    : 01 EQ, 10 GT, 11 LT, 00 illegal
//   in1        : operand A towards CMP_UNIT (holds last issued value)
//   in2        : operand B towards CMP_UNIT (holds last issued value)
//   cmp_fun    : function code towards CMP_UNIT (holds last issued value)
//   cmp_en     : one-cycle strobe per issued compare
//   cmp_out    : result from CMP_UNIT
//   cmp_flag   : CMP_UNIT result valid
//   rsp_valid  : response present
//   rsp_ready  : response consumed when rsp_valid & rsp_ready
//   rsp_result : captured cmp_out (0 for error responses)
//   rsp_true   : reduction-OR of rsp_result
//   rsp_err    : illegal function code or watchdog expiry
//   busy       : a request is in flight
//   txn_count  : completed responses (errors included), wraps silently
// -----------------------------------------------------------------------------
module cmp_issuer #(
    parameter int IN1_WIDTH      = 16,
    parameter int IN2_WIDTH      = 16,
    parameter int CMP_OUT_WIDTH  = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [IN1_WIDTH-1:0]     req_a,
    input  logic [IN2_WIDTH-1:0]     req_b,
    input  logic [1:0]               req_fun,
    output logic [IN1_WIDTH-1:0]     in1,
    output logic [IN2_WIDTH-1:0]     in2,
    output logic [1:0]               cmp_fun,
    output logic                     cmp_en,
    input  logic [CMP_OUT_WIDTH-1:0] cmp_out,
    input  logic                     cmp_flag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CMP_OUT_WIDTH-1:0] rsp_result,
    output logic                     rsp_true,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     txn_count
);

    // A zero watchdog limit would make every legal request fail before
    // CMP_UNIT could possibly answer, so reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cmp_issuer: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [1:0] FUN_ILLEGAL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                     state_q,      state_d;
    logic                       req_ready_q,  req_ready_d;
    logic [IN1_WIDTH-1:0]       in1_q,        in1_d;
    logic [IN2_WIDTH-1:0]       in2_q,        in2_d;
    logic [1:0]                 cmp_fun_q,    cmp_fun_d;
    logic                       cmp_en_q,     cmp_en_d;
    logic                       rsp_valid_q,  rsp_valid_d;
    logic [CMP_OUT_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                       rsp_true_q,   rsp_true_d;
    logic                       rsp_err_q,    rsp_err_d;
    logic                       busy_q,       busy_d;
    logic [CNT_WIDTH-1:0]       txn_count_q,  txn_count_d;

`ifdef CMP_ISSUER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Number of WAIT cycles already spent without cmp_flag.
    logic [TO_W-1:0]            to_cnt_q,     to_cnt_d;
`endif

    // Next-state and next-output logic. Every output is a flop, so the
    // values computed here describe what the ports will show in the cycle
    // after the coming clock edge. The operands double as the request latch:
    // they are loaded on acceptance of a legal request and otherwise held,
    // which keeps in1/in2/cmp_fun at their last issued values.
    always_comb begin
        state_d      = state_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        cmp_fun_d    = cmp_fun_q;
        cmp_en_d     = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        txn_count_d  = txn_count_q;
`ifdef CMP_ISSUER_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_fun == FUN_ILLEGAL) begin
                        // Never reaches CMP_UNIT; answer straight away.
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        in1_d     = req_a;
                        in2_d     = req_b;
                        cmp_fun_d = req_fun;
                        cmp_en_d  = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef CMP_ISSUER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                // A flag in the same cycle the watchdog expires still
                // produces a normal response.
                if (cmp_flag) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = cmp_out;
                    rsp_err_d    = 1'b0;
                end
`ifdef CMP_ISSUER_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end

            ST_RESP: begin
                // Payload is held untouched until the consumer takes it.
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_true_d  = |rsp_result_d;
    end

    // State and output registers. Reset parks the issuer in IDLE and throws
    // away anything in flight; only req_ready comes out of reset high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            in1_q        <= '0;
            in2_q        <= '0;
            cmp_fun_q    <= '0;
            cmp_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_true_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            cmp_fun_q    <= cmp_fun_d;
            cmp_en_q     <= cmp_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_true_q   <= rsp_true_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            txn_count_q  <= txn_count_d;
        end
    end

`ifdef CMP_ISSUER_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign req_ready  = req_ready_q;
    assign in1        = in1_q;
    assign in2        = in2_q;
    assign cmp_fun    = cmp_fun_q;
    assign cmp_en     = cmp_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_true   = rsp_true_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_cmp_issuer.sv
// -----------------------------------------------------------------------------
// tb_cmp_issuer
//
// Drives directed compare requests into cmp_issuer, with a small CMP_UNIT
// stand-in that answers one cycle after cmp_en (optionally later, or never).
// A transaction-level model tracks what the ports must show each cycle and
// one compare process checks it on every falling edge; the directed tasks
// add literal expectations for results, latencies and counters.
// -----------------------------------------------------------------------------
module tb_cmp_issuer;

    localparam int W    = 16;
    localparam int CNTW = 3;
    localparam int TO   = 15;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [W-1:0]    req_a;
    logic [W-1:0]    req_b;
    logic [1:0]      req_fun;
    logic [W-1:0]    in1;
    logic [W-1:0]    in2;
    logic [1:0]      cmp_fun;
    logic            cmp_en;
    logic [W-1:0]    cmp_out;
    logic            cmp_flag;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_result;
    logic            rsp_true;
    logic            rsp_err;
    logic            busy;
    logic [CNTW-1:0] txn_count;

    int errors = 0;
    int checks = 0;

    cmp_issuer #(
        .IN1_WIDTH     (W),
        .IN2_WIDTH     (W),
        .CMP_OUT_WIDTH (W),
        .CNT_WIDTH     (CNTW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_fun   (req_fun),
        .in1       (in1),
        .in2       (in2),
        .cmp_fun   (cmp_fun),
        .cmp_en    (cmp_en),
        .cmp_out   (cmp_out),
        .cmp_flag  (cmp_flag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_true  (rsp_true),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison reporting shared by the model checker and the directed tasks.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference compare rule used by the CMP_UNIT stand-in.
    function automatic logic [W-1:0] refCmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] f);
        case (f)
            2'b01:   return (a == b) ? W'(1) : W'(0);
            2'b10:   return (a >  b) ? W'(2) : W'(0);
            2'b11:   return (a <  b) ? W'(3) : W'(0);
            default: return W'(0);
        endcase
    endfunction

    // CMP_UNIT stand-in: answers stubDelay cycles after the registered
    // one-cycle result, or never while stubMute is set.
    int           stubDelay = 0;
    logic         stubMute  = 1'b0;
    logic         stubPend;
    int           stubCnt;
    logic [W-1:0] stubA, stubB;
    logic [1:0]   stubF;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_flag <= 1'b0;
            cmp_out  <= '0;
            stubPend <= 1'b0;
            stubCnt  <= 0;
            stubA    <= '0;
            stubB    <= '0;
            stubF    <= '0;
        end else begin
            cmp_flag <= 1'b0;
            if (cmp_en && !stubMute) begin
                if (stubDelay == 0) begin
                    cmp_flag <= 1'b1;
                    cmp_out  <= refCmp(in1, in2, cmp_fun);
                end else begin
                    stubPend <= 1'b1;
                    stubCnt  <= stubDelay - 1;
                    stubA    <= in1;
                    stubB    <= in2;
                    stubF    <= cmp_fun;
                end
            end else if (stubPend && !stubMute) begin
                if (stubCnt == 0) begin
                    cmp_flag <= 1'b1;
                    cmp_out  <= refCmp(stubA, stubB, stubF);
                    stubPend <= 1'b0;
                end else begin
                    stubCnt <= stubCnt - 1;
                end
            end
        end
    end

    // Transaction-level model: one request in flight, its response pending
    // or not, and the operands most recently handed to CMP_UNIT.
    logic            mBusy, mIssuing, mAwaiting, mHasResp;
    int              mWait;
    logic [W-1:0]    mResult, mIn1, mIn2;
    logic            mErr;
    logic [1:0]      mFun;
    logic [CNTW-1:0] mTxn;

    // Compare process: check the ports against the model, then advance the
    // model by the clock edge that follows, using the inputs now present.
    always @(negedge clk) begin
        if (!rst) begin
            mBusy = 1'b0; mIssuing = 1'b0; mAwaiting = 1'b0; mHasResp = 1'b0;
            mWait = 0; mResult = '0; mErr = 1'b0;
            mIn1 = '0; mIn2 = '0; mFun = '0; mTxn = '0;
        end

        checkOutput("req_ready", req_ready, !mBusy);
        checkOutput("busy", busy, mBusy);
        checkOutput("cmp_en", cmp_en, mIssuing);
        checkOutput("in1", in1, mIn1);
        checkOutput("in2", in2, mIn2);
        checkOutput("cmp_fun", cmp_fun, mFun);
        checkOutput("rsp_valid", rsp_valid, mHasResp);
        checkOutput("txn_count", txn_count, mTxn);
        if (mHasResp || !rst) begin
            checkOutput("rsp_result", rsp_result, mResult);
            checkOutput("rsp_true", rsp_true, |mResult);
            checkOutput("rsp_err", rsp_err, mErr);
        end

        if (rst) begin
            if (mHasResp) begin
                if (rsp_ready) begin
                    mHasResp = 1'b0;
                    mBusy    = 1'b0;
                    mTxn     = mTxn + 1'b1;
                end
            end else if (mIssuing) begin
                mIssuing  = 1'b0;
                mAwaiting = 1'b1;
                mWait     = 0;
            end else if (mAwaiting) begin
                if (cmp_flag) begin
                    mResult   = cmp_out;
                    mErr      = 1'b0;
                    mHasResp  = 1'b1;
                    mAwaiting = 1'b0;
                end
`ifdef CMP_ISSUER_TIMEOUT_EN
                else begin
                    mWait++;
                    if (mWait == TO) begin
                        mResult   = '0;
                        mErr      = 1'b1;
                        mHasResp  = 1'b1;
                        mAwaiting = 1'b0;
                    end
                end
`endif
            end else if (!mBusy && req_valid) begin
                mBusy = 1'b1;
                if (req_fun == 2'b00) begin
                    mResult  = '0;
                    mErr     = 1'b1;
                    mHasResp = 1'b1;
                end else begin
                    mIssuing = 1'b1;
                    mIn1     = req_a;
                    mIn2     = req_b;
                    mFun     = req_fun;
                end
            end
        end
    end

    // Present one request and return right after the edge that accepted it.
    task automatic sendRequest(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_fun   = fun;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("req_accept_seen", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Full transaction with literal expectations on payload, latency from
    // the accept edge, and number of cmp_en cycles; hold > 0 stalls the
    // response for that many extra cycles.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun,
                                 input int hold, input logic [W-1:0] expRes, input logic expTrue,
                                 input logic expErr, input int expLat, input int expEn);
        int   cycles;
        int   enCnt;
        logic got;
        cycles = 0;
        enCnt  = 0;
        got    = 1'b0;
        rsp_ready = (hold == 0);
        sendRequest(a, b, fun);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cycles++;
            if (cmp_en) enCnt++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rsp_arrived", got, 1'b1);
        checkOutput("lit_latency", cycles, expLat);
        checkOutput("lit_cmp_en_cycles", enCnt, expEn);
        checkOutput("lit_result", rsp_result, expRes);
        checkOutput("lit_true", rsp_true, expTrue);
        checkOutput("lit_err", rsp_err, expErr);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("bp_valid_held", rsp_valid, 1'b1);
            checkOutput("bp_result_held", rsp_result, expRes);
            checkOutput("bp_req_ready_low", req_ready, 1'b0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rsp_consumed", rsp_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("lit_reset_req_ready", req_ready, 1'b1);
        checkOutput("lit_reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("lit_reset_cmp_en", cmp_en, 1'b0);
        checkOutput("lit_reset_txn", txn_count, 0);
        rst = 1'b1;

        $display("[TB] EQ / GT / LT / backpressure / illegal");
        applyStimulus(16'd15, 16'd15, 2'b01, 0, 16'd1, 1'b1, 1'b0, 3, 1);
        checkOutput("lit_txn_after_eq", txn_count, 1);
        applyStimulus(16'd17, 16'd15, 2'b10, 0, 16'd2, 1'b1, 1'b0, 3, 1);
        applyStimulus(16'd3,  16'd15, 2'b10, 0, 16'd0, 1'b0, 1'b0, 3, 1);
        applyStimulus(16'd2,  16'd9,  2'b11, 5, 16'd3, 1'b1, 1'b0, 3, 1);
        checkOutput("lit_txn_after_bp", txn_count, 4);
        applyStimulus(16'd7,  16'd7,  2'b00, 0, 16'd0, 1'b0, 1'b1, 1, 0);
        checkOutput("lit_txn_after_illegal", txn_count, 5);

        $display("[TB] slow CMP_UNIT and counter wrap");
        stubDelay = 3;
        applyStimulus(16'd4, 16'd5, 2'b01, 0, 16'd0, 1'b0, 1'b0, 6, 1);
        stubDelay = 0;
        applyStimulus(16'd9,   16'd2,   2'b11, 0, 16'd0, 1'b0, 1'b0, 3, 1);
        applyStimulus(16'd100, 16'd100, 2'b01, 0, 16'd1, 1'b1, 1'b0, 3, 1);
        checkOutput("lit_txn_wrap", txn_count, 0);
        applyStimulus(16'hFFFF, 16'd0, 2'b00, 0, 16'd0, 1'b0, 1'b1, 1, 0);
        checkOutput("lit_txn_after_wrap", txn_count, 1);

        $display("[TB] reset while waiting for CMP_UNIT");
        stubMute = 1'b1;
        sendRequest(16'd1, 16'd1, 2'b01);
        repeat (4) @(negedge clk);
        checkOutput("lit_wait_busy", busy, 1'b1);
        checkOutput("lit_wait_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        checkOutput("lit_rst_cmp_en", cmp_en, 1'b0);
        checkOutput("lit_rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("lit_rst_req_ready", req_ready, 1'b1);
        checkOutput("lit_rst_busy", busy, 1'b0);
        checkOutput("lit_rst_txn", txn_count, 0);
        @(posedge clk); #1;
        rst      = 1'b1;
        stubMute = 1'b0;
        applyStimulus(16'd15, 16'd15, 2'b01, 0, 16'd1, 1'b1, 1'b0, 3, 1);
        checkOutput("lit_txn_after_reset", txn_count, 1);

`ifdef CMP_ISSUER_TIMEOUT_EN
        $display("[TB] watchdog expiry");
        stubMute = 1'b1;
        applyStimulus(16'd5, 16'd1, 2'b10, 0, 16'd0, 1'b0, 1'b1, TO + 2, 1);
        stubMute = 1'b0;
        checkOutput("lit_txn_after_timeout", txn_count, 2);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
